// File: rtl/hazard_stall_scheduler.sv
// rtl/hazard_stall_scheduler.sv - pipeline stall/flush sequencer for the 5-stage RV32IM core
//
// Purpose: merges load-use stalls, iterative-divider occupancy and taken-branch
// flushes into a single set of pipeline-register enables, and counts stall cycles.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   ins          instruction currently held in IF/ID
//   idex_rd      rd of the instruction in ID/EX
//   idex_memrd   MemRead of the instruction in ID/EX
//   branch_taken EX-stage branch/jump resolved taken this cycle
//   control      1 = pass decoded controls into ID/EX, 0 = bubble
//   PCWrite      PC write enable
//   IFIDWrite    IF/ID write enable
//   ifid_flush   clear IF/ID to NOP at next edge
//   idex_flush   clear ID/EX to bubble at next edge
//   idex_hold    freeze ID/EX while the divider is busy
//   div_start    one-cycle start pulse to the EX divider
//   stall_count  saturating count of cycles with PCWrite=0

module hazard_stall_scheduler #(
   parameter int unsigned DIV_LAT = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ins,
   input  logic [4:0]       idex_rd,
   input  logic             idex_memrd,
   input  logic             branch_taken,
   output logic             control,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             idex_hold,
   output logic             div_start,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      DIV_BUSY = 1'b1
   } state_e;

   localparam logic [7:0]       BUSY_INIT = 8'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [7:0]       busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Instruction decode
   logic [6:0] opc;
   logic [4:0] rs1, rs2;
   logic       uses_rs1, uses_rs2, is_div;
   logic       load_use, flush;
   logic       unused_ins_bits;

   assign opc = ins[6:0];
   assign rs1 = ins[19:15];
   assign rs2 = ins[24:20];

   // rd and funct3[1:0] play no part in hazard detection
   assign unused_ins_bits = ^{ins[13:7]};

   assign uses_rs1 = !((opc == 7'b0110111) || (opc == 7'b0010111) || (opc == 7'b1101111));
   assign uses_rs2 = (opc == 7'b0110011) || (opc == 7'b0100011) || (opc == 7'b1100011);
   assign is_div   = (opc == 7'b0110011) && (ins[31:25] == 7'b0000001) && ins[14];

   // x0 is never a real producer, so idex_rd==0 cannot stall
   assign load_use = idex_memrd && (idex_rd != 5'd0) &&
                     ((uses_rs1 && (rs1 == idex_rd)) || (uses_rs2 && (rs2 == idex_rd)));
   assign flush    = branch_taken && (state_q == RUN);

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      control    = 1'b0;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      idex_hold  = 1'b0;
      div_start  = 1'b0;

      case (state_q)
         RUN: begin
            if (flush) begin
               // Squash the wrong-path pair; a divide or hazard in ID dies with it
               PCWrite    = 1'b1;
               IFIDWrite  = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               // Bubble clears idex_memrd next cycle, so this is a single stall
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               control   = 1'b0;
            end else if (is_div) begin
               PCWrite   = 1'b1;
               IFIDWrite = 1'b1;
               control   = 1'b1;
               div_start = 1'b1;
               busy_d    = BUSY_INIT;
               state_d   = DIV_BUSY;
            end else begin
               PCWrite   = 1'b1;
               IFIDWrite = 1'b1;
               control   = 1'b1;
            end
         end

         DIV_BUSY: begin
            // Divide occupies EX; freeze front end and ID/EX, ignore branches/hazards
            control   = 1'b1;
            idex_hold = 1'b1;
            busy_d    = busy_q - 8'd1;
            if (busy_q == 8'd1) begin
               state_d = RUN;
               busy_d  = 8'd0;
            end
         end

         default: begin
            state_d = RUN;
            busy_d  = 8'd0;
         end
      endcase

      // Outputs are forced low for the whole time reset is held
      if (!rst_n) begin
         control    = 1'b0;
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b0;
         idex_hold  = 1'b0;
         div_start  = 1'b0;
      end
   end

   // Saturating stall counter
   always_comb begin
      cnt_d = cnt_q;
      if (!PCWrite && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         busy_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_scheduler.sv
// tb/tb_hazard_stall_scheduler.sv - scoreboard testbench for hazard_stall_scheduler

module tb_hazard_stall_scheduler;

   localparam int unsigned DIV_LAT = 8;
   localparam int unsigned CNT_W   = 4;

   localparam logic [31:0] INS_ADD  = 32'h00030433;  // add  x8,x6,x0
   localparam logic [31:0] INS_ADDI = 32'h00638413;  // addi x8,x7,6
   localparam logic [31:0] INS_DIV  = 32'h027342B3;  // div  x5,x6,x7
   localparam logic [31:0] INS_NOP  = 32'h00000013;  // addi x0,x0,0

   // Flag order: {control, PCWrite, IFIDWrite, ifid_flush, idex_flush, idex_hold, div_start}
   localparam logic [6:0] F_NORMAL = 7'b1110000;
   localparam logic [6:0] F_STALL  = 7'b0000000;
   localparam logic [6:0] F_FLUSH  = 7'b0111100;
   localparam logic [6:0] F_DIV    = 7'b1110001;
   localparam logic [6:0] F_BUSY   = 7'b1000010;

   typedef struct packed {
      logic [6:0]       flags;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      ins;
   logic [4:0]       idex_rd;
   logic             idex_memrd;
   logic             branch_taken;
   logic             control, PCWrite, IFIDWrite, ifid_flush, idex_flush, idex_hold, div_start;
   logic [CNT_W-1:0] stall_count;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int unsigned      m_busy = 0;
   logic [CNT_W-1:0] m_cnt  = '0;

   hazard_stall_scheduler #(
      .DIV_LAT(DIV_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ins         (ins),
      .idex_rd     (idex_rd),
      .idex_memrd  (idex_memrd),
      .branch_taken(branch_taken),
      .control     (control),
      .PCWrite     (PCWrite),
      .IFIDWrite   (IFIDWrite),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .idex_hold   (idex_hold),
      .div_start   (div_start),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] dut_flags();
      return {control, PCWrite, IFIDWrite, ifid_flush, idex_flush, idex_hold, div_start};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, push the model's expectation, compare at negedge
   task automatic step(input string tag, input logic [31:0] i, input logic [4:0] rd,
                       input logic mr, input logic br);
      logic [6:0] opc;
      logic       u1, u2, dv, ld;
      exp_t       e, got;
      ins          = i;
      idex_rd      = rd;
      idex_memrd   = mr;
      branch_taken = br;

      opc = i[6:0];
      u1  = !(opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111);
      u2  = (opc == 7'b0110011 || opc == 7'b0100011 || opc == 7'b1100011);
      dv  = (opc == 7'b0110011) && (i[31:25] == 7'b0000001) && i[14];
      ld  = mr && (rd != 5'd0) && ((u1 && i[19:15] == rd) || (u2 && i[24:20] == rd));

      if (m_busy != 0)  e.flags = F_BUSY;
      else if (br)      e.flags = F_FLUSH;
      else if (ld)      e.flags = F_STALL;
      else if (dv)      e.flags = F_DIV;
      else              e.flags = F_NORMAL;
      e.cnt = m_cnt;
      sb_q.push_back(e);

      @(negedge clk);
      got = sb_q.pop_front();
      check({tag, ".flags"}, 32'(dut_flags()), 32'(got.flags));
      check({tag, ".cnt"}, 32'(stall_count), 32'(got.cnt));

      if (m_busy != 0)                m_busy = m_busy - 1;
      else if (e.flags == F_DIV)      m_busy = DIV_LAT - 1;
      if (!e.flags[5] && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;

      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      ins          = INS_NOP;
      idex_rd      = 5'd0;
      idex_memrd   = 1'b0;
      branch_taken = 1'b1;
      #2;
      check("reset.flags", 32'(dut_flags()), 32'h0);
      check("reset.cnt", 32'(stall_count), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Load-use stall, then the bubble clears MemRead
      step("lu_stall", INS_ADD, 5'd6, 1'b1, 1'b0);
      step("lu_after", INS_ADD, 5'd6, 1'b0, 1'b0);
      // ALU producer: no stall
      step("alu_prod", INS_ADD, 5'd6, 1'b0, 1'b0);
      // I-type rs2 field must not alias
      step("itype_rs2", INS_ADDI, 5'd6, 1'b1, 1'b0);
      step("itype_rs1", INS_ADDI, 5'd7, 1'b1, 1'b0);
      step("itype_after", INS_ADDI, 5'd7, 1'b0, 1'b0);
      // x0 never stalls (add has rs2=x0)
      step("x0_rd", INS_ADD, 5'd0, 1'b1, 1'b0);

      // Divider sequencing with a branch pulse during busy
      step("div_start", INS_DIV, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < int'(DIV_LAT) - 1; k++) begin
         step($sformatf("div_busy%0d", k), INS_NOP, 5'd6, 1'b1, (k == 2));
      end
      step("div_done", INS_NOP, 5'd0, 1'b0, 1'b0);

      // Back-to-back divides; stall counter saturates along the way
      step("b2b_start0", INS_DIV, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < int'(DIV_LAT) - 1; k++) begin
         step($sformatf("b2b_busy_a%0d", k), INS_DIV, 5'd0, 1'b0, 1'b0);
      end
      step("b2b_start1", INS_DIV, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < int'(DIV_LAT) - 1; k++) begin
         step($sformatf("b2b_busy_b%0d", k), INS_NOP, 5'd0, 1'b0, 1'b0);
      end
      step("b2b_done", INS_NOP, 5'd0, 1'b0, 1'b0);

      // Flush beats load-use and divide in the same cycle
      step("flush_prio", INS_DIV, 5'd6, 1'b1, 1'b1);
      step("flush_after", INS_NOP, 5'd0, 1'b0, 1'b0);

      // Async reset mid-divide, at busy cycle 3
      step("rst_div_start", INS_DIV, 5'd0, 1'b0, 1'b0);
      step("rst_busy0", INS_NOP, 5'd0, 1'b0, 1'b0);
      step("rst_busy1", INS_NOP, 5'd0, 1'b0, 1'b0);
      ins          = INS_NOP;
      branch_taken = 1'b1;
      #2;
      check("rst_mid.pre_hold", 32'(idex_hold), 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid.flags", 32'(dut_flags()), 32'h0);
      check("rst_mid.cnt", 32'(stall_count), 32'h0);
      @(posedge clk);
      #3;
      check("rst_held.flags", 32'(dut_flags()), 32'h0);
      branch_taken = 1'b0;
      rst_n        = 1'b1;
      m_busy       = 0;
      m_cnt        = '0;
      step("rst_release", INS_NOP, 5'd0, 1'b0, 1'b0);
      step("rst_release2", INS_NOP, 5'd0, 1'b0, 1'b0);

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
